// File: rtl/int_issue.sv
`default_nettype none
// ============================================================================
// Module   : int_issue
// Brief    : Integer issue stage. Reads operands from a 32x64 register file,
//            stalls on scoreboard hazards, and holds one registered payload
//            for the ALU. ALU writebacks update the register file and the
//            scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module int_issue (
   input  logic        clk_i,
   input  logic        rsn_i,
   input  logic        instr_valid_i,
   input  logic [31:0] instr_i,
   output logic        instr_ready_o,
   output logic        alu_valid_o,
   input  logic        alu_ready_i,
   output logic [31:0] alu_instr_o,
   output logic [63:0] alu_data_a_o,
   output logic [63:0] alu_data_b_o,
   output logic [4:0]  alu_rd_o,
   input  logic        wb_valid_i,
   input  logic [4:0]  wb_rd_i,
   input  logic [63:0] wb_data_i,
   output logic        illegal_o
);

   localparam logic [6:0] C_OPC_OP     = 7'b0110011;
   localparam logic [6:0] C_OPC_OP_IMM = 7'b0010011;

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_state_next;

   logic [63:0] r_regs [32];
   logic [31:1] r_busy;
   logic [31:1] w_busy_next;
   logic [31:0] r_alu_instr;
   logic [63:0] r_alu_a;
   logic [63:0] r_alu_b;
   logic [4:0]  r_alu_rd;
   logic        r_illegal;

   logic [6:0]  w_opcode;
   logic [4:0]  w_rd;
   logic [4:0]  w_rs1;
   logic [4:0]  w_rs2;
   logic        w_is_op;
   logic        w_legal;
   logic [31:0] w_wb_clr;
   logic [31:0] w_busy_eff;
   logic        w_hazard;
   logic        w_ready;
   logic        w_accept;
   logic        w_accept_legal;
   logic        w_load;
   logic [63:0] w_rs1_val;
   logic [63:0] w_rs2_val;
   logic [63:0] w_imm;

   // Field decode, hazard detection and the upstream handshake
   always_comb begin
      w_opcode       = instr_i[6:0];
      w_rd           = instr_i[11:7];
      w_rs1          = instr_i[19:15];
      w_rs2          = instr_i[24:20];
      w_is_op        = (w_opcode == C_OPC_OP);
      w_legal        = w_is_op || (w_opcode == C_OPC_OP_IMM);
      w_imm          = {{52{instr_i[31]}}, instr_i[31:20]};
      // A register being written back this cycle is no longer pending
      w_wb_clr       = wb_valid_i ? (32'd1 << wb_rd_i) : 32'd0;
      w_busy_eff     = {r_busy, 1'b0} & ~w_wb_clr;
      w_hazard       = w_legal && (w_busy_eff[w_rs1] ||
                       (w_is_op && (w_busy_eff[w_rs2] || w_busy_eff[w_rd])));
      w_ready        = ((r_state == ST_EMPTY) || alu_ready_i) && !w_hazard;
      w_accept       = instr_valid_i && w_ready;
      w_accept_legal = w_accept && w_legal;
   end

   // Operand read with write-through forwarding from the writeback port
   always_comb begin
      w_rs1_val = 64'd0;
      w_rs2_val = 64'd0;
      if (w_rs1 != 5'd0) begin
         w_rs1_val = (wb_valid_i && (wb_rd_i == w_rs1)) ? wb_data_i : r_regs[w_rs1];
      end
      if (w_rs2 != 5'd0) begin
         w_rs2_val = (wb_valid_i && (wb_rd_i == w_rs2)) ? wb_data_i : r_regs[w_rs2];
      end
   end

   // Scoreboard next value: clear on writeback, set on issue (set wins)
   always_comb begin
      w_busy_next = r_busy;
      for (int i = 1; i < 32; i++) begin
         if (wb_valid_i && (wb_rd_i == 5'(i))) begin
            w_busy_next[i] = 1'b0;
         end
         if (w_accept_legal && (w_rd == 5'(i))) begin
            w_busy_next[i] = 1'b1;
         end
      end
   end

   // Output stage next-state and payload-load decision
   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (w_accept_legal) begin
               w_state_next = ST_FULL;
               w_load       = 1'b1;
            end
         end
         ST_FULL: begin
            if (alu_ready_i) begin
               if (w_accept_legal) begin
                  w_state_next = ST_FULL;
                  w_load       = 1'b1;
               end else begin
                  w_state_next = ST_EMPTY;
               end
            end
         end
         default: w_state_next = ST_EMPTY;
      endcase
   end

   // Output stage state register
   always_ff @(posedge clk_i or posedge rsn_i) begin
      if (rsn_i) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Payload register, held stable while the ALU back-pressures
   always_ff @(posedge clk_i or posedge rsn_i) begin
      if (rsn_i) begin
         r_alu_instr <= 32'd0;
         r_alu_a     <= 64'd0;
         r_alu_b     <= 64'd0;
         r_alu_rd    <= 5'd0;
      end else if (w_load) begin
         r_alu_instr <= instr_i;
         r_alu_a     <= w_rs1_val;
         r_alu_b     <= w_is_op ? w_rs2_val : w_imm;
         r_alu_rd    <= w_rd;
      end
   end

   // Scoreboard and one-cycle illegal-opcode pulse
   always_ff @(posedge clk_i or posedge rsn_i) begin
      if (rsn_i) begin
         r_busy    <= '0;
         r_illegal <= 1'b0;
      end else begin
         r_busy    <= w_busy_next;
         r_illegal <= w_accept && !w_legal;
      end
   end

   // Register file; x0 is never written so it reads as zero
   always_ff @(posedge clk_i or posedge rsn_i) begin
      if (rsn_i) begin
         for (int i = 0; i < 32; i++) begin
            r_regs[i] <= 64'd0;
         end
      end else if (wb_valid_i && (wb_rd_i != 5'd0)) begin
         r_regs[wb_rd_i] <= wb_data_i;
      end
   end

   assign instr_ready_o = w_ready;
   assign alu_valid_o   = (r_state == ST_FULL);
   assign alu_instr_o   = r_alu_instr;
   assign alu_data_a_o  = r_alu_a;
   assign alu_data_b_o  = r_alu_b;
   assign alu_rd_o      = r_alu_rd;
   assign illegal_o     = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_int_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_int_issue
// Brief    : Scoreboard bench for int_issue: directed scenarios followed by
//            random traffic against a queue/array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_int_issue;

   logic        clk_i = 1'b0;
   logic        rsn_i = 1'b1;
   logic        instr_valid_i = 1'b0;
   logic [31:0] instr_i = '0;
   logic        instr_ready_o;
   logic        alu_valid_o;
   logic        alu_ready_i = 1'b1;
   logic [31:0] alu_instr_o;
   logic [63:0] alu_data_a_o;
   logic [63:0] alu_data_b_o;
   logic [4:0]  alu_rd_o;
   logic        wb_valid_i = 1'b0;
   logic [4:0]  wb_rd_i = '0;
   logic [63:0] wb_data_i = '0;
   logic        illegal_o;

   int_issue dut (
      .clk_i         (clk_i),
      .rsn_i         (rsn_i),
      .instr_valid_i (instr_valid_i),
      .instr_i       (instr_i),
      .instr_ready_o (instr_ready_o),
      .alu_valid_o   (alu_valid_o),
      .alu_ready_i   (alu_ready_i),
      .alu_instr_o   (alu_instr_o),
      .alu_data_a_o  (alu_data_a_o),
      .alu_data_b_o  (alu_data_b_o),
      .alu_rd_o      (alu_rd_o),
      .wb_valid_i    (wb_valid_i),
      .wb_rd_i       (wb_rd_i),
      .wb_data_i     (wb_data_i),
      .illegal_o     (illegal_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] instr;
      logic [63:0] a;
      logic [63:0] b;
      logic [4:0]  rd;
   } exp_t;

   exp_t        exp_q [$];
   bit          ill_q [$];
   logic [63:0] m_regs [32];
   bit          m_pend [32];
   int          n_checks = 0;
   int          n_pass   = 0;

   task automatic check(input string name, input bit ok,
                        input logic [191:0] act, input logic [191:0] req);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0h required %0h", name, act, req);
   endtask

   function automatic logic [31:0] enc_op(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
      return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_imm(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [11:0] imm);
      return {imm, rs1, 3'b000, rd, 7'b0010011};
   endfunction

   function automatic bit pend_eff(input logic [4:0] r);
      return (r != 5'd0) && m_pend[r] && !(wb_valid_i && (wb_rd_i == r));
   endfunction

   function automatic logic [63:0] rd_val(input logic [4:0] r);
      if (r == 5'd0) return 64'd0;
      if (wb_valid_i && (wb_rd_i == r)) return wb_data_i;
      return m_regs[r];
   endfunction

   // Reference model step for the inputs currently applied (before the edge)
   task automatic model_step();
      logic [6:0] op;
      logic [4:0] rd, rs1, rs2;
      bit is_op, legal, haz, rdy, acc;
      exp_t e;
      op    = instr_i[6:0];
      rd    = instr_i[11:7];
      rs1   = instr_i[19:15];
      rs2   = instr_i[24:20];
      is_op = (op == 7'h33);
      legal = is_op || (op == 7'h13);
      haz   = legal && (pend_eff(rs1) || (is_op && (pend_eff(rs2) || pend_eff(rd))));
      rdy   = ((exp_q.size() == 0) || alu_ready_i) && !haz;
      check("instr_ready_o", instr_ready_o == rdy, 192'(instr_ready_o), 192'(rdy));
      acc = instr_valid_i && rdy;
      if (acc && legal) begin
         e.instr = instr_i;
         e.a     = rd_val(rs1);
         e.b     = is_op ? rd_val(rs2) : {{52{instr_i[31]}}, instr_i[31:20]};
         e.rd    = rd;
         exp_q.push_back(e);
      end
      ill_q.push_back(acc && !legal);
      if (wb_valid_i) begin
         m_pend[wb_rd_i] = 1'b0;
         if (wb_rd_i != 5'd0) m_regs[wb_rd_i] = wb_data_i;
      end
      if (acc && legal && (rd != 5'd0)) m_pend[rd] = 1'b1;
   endtask

   task automatic cycle(input bit v, input logic [31:0] ins, input bit ar,
                        input bit wv, input logic [4:0] wr, input logic [63:0] wd);
      @(negedge clk_i);
      rsn_i = 1'b0;
      instr_valid_i = v; instr_i = ins; alu_ready_i = ar;
      wb_valid_i = wv; wb_rd_i = wr; wb_data_i = wd;
      #2;
      model_step();
   endtask

   task automatic model_clear();
      exp_q.delete();
      ill_q.delete();
      ill_q.push_back(1'b0);
      for (int i = 0; i < 32; i++) begin
         m_regs[i] = 64'd0;
         m_pend[i] = 1'b0;
      end
   endtask

   task automatic async_reset();
      @(negedge clk_i);
      instr_valid_i = 1'b0; wb_valid_i = 1'b0; alu_ready_i = 1'b0;
      #3 rsn_i = 1'b1;
      #1;
      check("reset alu_valid_o", alu_valid_o == 1'b0, 192'(alu_valid_o), 192'(0));
      check("reset alu_instr_o", alu_instr_o == 32'd0, 192'(alu_instr_o), 192'(0));
      model_clear();
   endtask

   // Monitor: compares the presented output against the scoreboard each cycle
   initial begin
      exp_t e;
      bit   ie;
      forever begin
         @(negedge clk_i);
         #1;
         if (!rsn_i) begin
            ie = (ill_q.size() != 0) ? ill_q.pop_front() : 1'b0;
            check("illegal_o", illegal_o == ie, 192'(illegal_o), 192'(ie));
            check("alu_valid_o", alu_valid_o == (exp_q.size() != 0),
                  192'(alu_valid_o), 192'(exp_q.size() != 0));
            if (alu_valid_o && alu_ready_i && (exp_q.size() != 0)) begin
               e = exp_q.pop_front();
               check("payload {instr,a,b,rd}",
                     (alu_instr_o == e.instr) && (alu_data_a_o == e.a) &&
                     (alu_data_b_o == e.b) && (alu_rd_o == e.rd),
                     192'({alu_instr_o, alu_data_a_o, alu_data_b_o, alu_rd_o}),
                     192'({e.instr, e.a, e.b, e.rd}));
            end
         end
      end
   end

   // Stimulus: directed scenarios, then random traffic, then drain
   initial begin
      model_clear();
      repeat (2) @(negedge clk_i);

      // Basic issue of add x7,x5,x6 with operands from writebacks
      cycle(0, 32'd0, 1, 1, 5'd5, 64'h10);
      cycle(0, 32'd0, 1, 1, 5'd6, 64'h20);
      cycle(1, 32'h006283B3, 1, 0, 5'd0, 64'd0);
      // RAW stall on x7, released by a same-cycle writeback
      repeat (3) cycle(1, enc_imm(5'd8, 5'd7, 12'd1), 1, 0, 5'd0, 64'd0);
      cycle(1, enc_imm(5'd8, 5'd7, 12'd1), 1, 1, 5'd7, 64'h30);
      cycle(0, 32'd0, 1, 1, 5'd8, 64'h31);
      // Backpressure with two independent instructions
      cycle(1, enc_op(5'd9, 5'd1, 5'd2), 0, 0, 5'd0, 64'd0);
      repeat (2) cycle(1, enc_op(5'd10, 5'd3, 5'd4), 0, 0, 5'd0, 64'd0);
      cycle(1, enc_op(5'd10, 5'd3, 5'd4), 1, 0, 5'd0, 64'd0);
      cycle(0, 32'd0, 1, 1, 5'd9, 64'h99);
      cycle(0, 32'd0, 1, 1, 5'd10, 64'hAA);
      // x0 writes ignored, negative immediate sign-extended
      cycle(0, 32'd0, 1, 1, 5'd0, 64'hFF);
      cycle(1, 32'hFFF00093, 1, 0, 5'd0, 64'd0);
      cycle(0, 32'd0, 1, 1, 5'd1, 64'h1234);
      // Illegal opcode
      cycle(1, 32'h0000007F, 1, 0, 5'd0, 64'd0);
      repeat (2) cycle(0, 32'd0, 1, 0, 5'd0, 64'd0);
      // Async reset while FULL with x7 pending
      cycle(1, enc_op(5'd7, 5'd5, 5'd6), 0, 0, 5'd0, 64'd0);
      cycle(0, 32'd0, 0, 0, 5'd0, 64'd0);
      async_reset();
      cycle(1, enc_op(5'd8, 5'd7, 5'd7), 1, 0, 5'd0, 64'd0);
      cycle(0, 32'd0, 1, 1, 5'd8, 64'h5);

      // Random traffic over a small register window to provoke hazards
      for (int c = 0; c < 600; c++) begin
         int          k;
         int          pl [$];
         logic [31:0] ins;
         logic [6:0]  op;
         bit          wv;
         logic [4:0]  wr;
         k = $urandom_range(0, 9);
         if (k <= 3) begin
            ins = enc_op(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                         5'($urandom_range(0, 7)));
         end else if (k <= 7) begin
            ins = enc_imm(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 12'($urandom));
         end else begin
            ins = $urandom;
            op  = ins[6:0];
            if ((op == 7'h33) || (op == 7'h13)) ins[6:0] = 7'h7F;
         end
         for (int r = 1; r < 8; r++) if (m_pend[r]) pl.push_back(r);
         wv = ($urandom_range(0, 1) == 1);
         if ((pl.size() != 0) && ($urandom_range(0, 3) != 0))
            wr = 5'(pl[$urandom_range(0, pl.size() - 1)]);
         else
            wr = 5'($urandom_range(0, 31));
         cycle((k != 9), ins, ($urandom_range(0, 3) != 0), wv, wr,
               {32'($urandom), 32'($urandom)});
      end

      // Drain: retire every pending register and let the output empty
      for (int r = 1; r < 32; r++) cycle(0, 32'd0, 1, 1, 5'(r), 64'(r));
      repeat (2) cycle(0, 32'd0, 1, 0, 5'd0, 64'd0);
      check("final queue empty", exp_q.size() == 0, 192'(exp_q.size()), 192'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
